// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU clock-enable generator: turbo codes and the
// period lookup used by both the divider and anything that needs to know P.
package cpu_pkg;

  localparam int DIV_BASE_DEFAULT = 16;

  typedef enum logic [1:0] {
    TURBO_X1 = 2'd0,
    TURBO_X2 = 2'd1,
    TURBO_X4 = 2'd2,
    TURBO_X8 = 2'd3
  } turbo_e;

  // Master clocks per CPU clock for a given turbo code.
  function automatic int period_of(input logic [1:0] mode, input int div_base = DIV_BASE_DEFAULT);
    return div_base >> mode;
  endfunction

endpackage

// File: rtl/cpu_cegen.sv
// cep/cen pulse generator for the T80 wrapper: divides the system clock by a
// turbo-selectable period and drops whole CPU clocks while contention is requested.
module cpu_cegen
  import cpu_pkg::*;
#(
  parameter int DIV_BASE  = DIV_BASE_DEFAULT,
  parameter int MAX_TURBO = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] turbo,
  input  logic       contend,
  output logic       cep,
  output logic       cen,
  output logic       cpuclk,
  output logic [1:0] mode,
  output logic       stalled
);

  localparam int         CW   = $clog2(DIV_BASE);
  localparam logic [1:0] MAXT = 2'(MAX_TURBO);

  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic [CW-1:0] half;
  logic          hold;
  logic          bnd;
  int            per;
  turbo_e        req;

  // P never exceeds DIV_BASE, so P-1 and P/2-1 always fit in the counter width.
  assign per  = period_of(mode, DIV_BASE);
  assign last = CW'(per - 1);
  assign half = CW'(per / 2 - 1);
  assign bnd  = (cnt == last);
  assign req  = turbo_e'((turbo > MAXT) ? MAXT : turbo);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      mode    <= TURBO_X1;
      hold    <= 1'b0;
      cep     <= 1'b0;
      cen     <= 1'b0;
      cpuclk  <= 1'b0;
      stalled <= 1'b0;
    end else begin
      cep <= 1'b0;
      cen <= 1'b0;
      // Rate and contention are latched together so a period is never split.
      if (bnd) begin
        cnt     <= '0;
        cep     <= ~contend;
        hold    <= contend;
        stalled <= contend;
        mode    <= req;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (cnt == half) cen <= ~hold;
      if (cep)      cpuclk <= 1'b1;
      else if (cen) cpuclk <= 1'b0;
    end
  end

  a_excl: assert property (@(posedge clock) disable iff (reset) !(cep && cen));
  a_mode: assert property (@(posedge clock) disable iff (reset) (mode != $past(mode)) |-> $past(bnd));

endmodule

// File: tb/tb_cpu_cegen.sv
// Scoreboard bench for cpu_cegen: two instances (MAX_TURBO 3 and 2) share
// stimulus; a period-level schedule model predicts every pulse and level.
module tb_cpu_cegen;
  import cpu_pkg::*;

  localparam int DIV = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] turbo = 2'd0;
  logic       contend = 1'b0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct { int t; int v; } ev_t;
  typedef struct { int t; int m; int s; } st_t;

  always #5 clock = ~clock;

  // Edge number since reset release: edge 1 is the first non-reset edge.
  always @(posedge clock) begin
    if (reset) cyc = 0;
    else       cyc = cyc + 1;
  end

  task automatic chk(input int inst, input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL u%0d %s edge=%0d got %0d want %0d", inst, nm, cyc, act, exp_v);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int MT = (g == 0) ? 3 : 2;

    logic       cep, cen, cpuclk, stalled;
    logic [1:0] mode;

    cpu_cegen #(.DIV_BASE(DIV), .MAX_TURBO(MT)) dut (
      .clock(clock), .reset(reset), .turbo(turbo), .contend(contend),
      .cep(cep), .cen(cen), .cpuclk(cpuclk), .mode(mode), .stalled(stalled)
    );

    int  cepq[$];
    int  cenq[$];
    ev_t clkq[$];
    st_t stq[$];
    int  next_bnd;
    int  m, p;
    bit  c;

    // Model: at each negedge, inputs are what the coming edge will sample.
    // A boundary at edge b with period p schedules cep at b, cen at b+p/2.
    always @(negedge clock) begin
      if (reset) begin
        cepq.delete(); cenq.delete(); clkq.delete(); stq.delete();
        next_bnd = DIV;
        cenq.push_back(DIV / 2);
        clkq.push_back(ev_t'{DIV / 2 + 1, 0});
      end else if (cyc + 1 == next_bnd) begin
        c = contend;
        m = (int'(turbo) > MT) ? MT : int'(turbo);
        p = DIV >> m;
        stq.push_back(st_t'{next_bnd, m, int'(c)});
        if (!c) begin
          cepq.push_back(next_bnd);
          clkq.push_back(ev_t'{next_bnd + 1, 1});
          cenq.push_back(next_bnd + p / 2);
          clkq.push_back(ev_t'{next_bnd + p / 2 + 1, 0});
        end
        next_bnd += p;
      end
    end

    int emode = 0, estall = 0, eclk = 0;

    // Monitor: pops expectations as the DUT presents pulses, flags misses.
    always @(negedge clock) begin
      if (reset) begin
        emode = 0; estall = 0; eclk = 0;
        chk(g, "reset_outputs", int'({cep, cen, cpuclk, stalled, mode}), 0);
      end else begin
        while (stq.size() > 0 && stq[0].t <= cyc) begin
          emode  = stq[0].m;
          estall = stq[0].s;
          void'(stq.pop_front());
        end
        while (clkq.size() > 0 && clkq[0].t <= cyc) begin
          eclk = clkq[0].v;
          void'(clkq.pop_front());
        end
        if (cep) begin
          if (cepq.size() == 0) chk(g, "cep_unexpected", cyc, -1);
          else                  chk(g, "cep_edge", cyc, cepq.pop_front());
        end else if (cepq.size() > 0 && cepq[0] <= cyc) begin
          chk(g, "cep_missing", -1, cepq.pop_front());
        end
        if (cen) begin
          if (cenq.size() == 0) chk(g, "cen_unexpected", cyc, -1);
          else                  chk(g, "cen_edge", cyc, cenq.pop_front());
        end else if (cenq.size() > 0 && cenq[0] <= cyc) begin
          chk(g, "cen_missing", -1, cenq.pop_front());
        end
        chk(g, "mode", int'(mode), emode);
        chk(g, "stalled", int'(stalled), estall);
        chk(g, "cpuclk", int'(cpuclk), eclk);
      end
    end
  end

  task automatic do_reset(input int n);
    @(posedge clock); #1 reset = 1'b1;
    turbo = 2'd0; contend = 1'b0;
    repeat (n) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    // Base rate, then turbo=3 requested mid-period before edge 20.
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (19) @(posedge clock);
    #1 turbo = 2'd3;
    repeat (40) @(posedge clock);

    // Contention for the single clock ahead of edge 32.
    do_reset(2);
    repeat (31) @(posedge clock);
    #1 contend = 1'b1;
    @(posedge clock);
    #1 contend = 1'b0;
    repeat (40) @(posedge clock);

    // Reset in the middle of a period, held for 3 clocks.
    do_reset(2);
    repeat (26) @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (40) @(posedge clock);

    // Randomized turbo/contention with occasional resets.
    repeat (10000) begin
      @(posedge clock);
      #1;
      if ($urandom_range(0, 15) == 0) turbo = 2'($urandom_range(0, 3));
      contend = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2999) == 0) reset = 1'b1;
      else                              reset = 1'b0;
    end
    @(posedge clock);
    #1 reset = 1'b0; contend = 1'b0;
    repeat (40) @(posedge clock);
    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
